mips_alu_issue: RTL and testbench
=================================

# mips_alu_issue

Multi-cycle issue and writeback sequencer that drives `mipsALU` from the control side. It accepts one 32-bit MIPS instruction over a valid/ready handshake and decodes the opcode/funct into `alu_ctl`. It drives the ALU operands from an internal 32 x 8-bit register file, then captures `alu_out`/`zero` and writes the result back. It sits between the instruction source and the ALU datapath in the 8-bit MIPS subset.

## Interface
- No parameters; data width is fixed at 8 bits, 32 registers.
- `clk` in 1: single clock; all state changes on its rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `instr_valid` in 1: instruction offered.
- `instr` in 32: MIPS instruction; fields are `op=[31:26]`, `rs=[25:21]`, `rt=[20:16]`, `rd=[15:11]`, `funct=[5:0]`, `imm=[7:0]`.
- `instr_ready` out 1: sequencer can accept an instruction.
- `alu_ctl` out 4: ALU operation code, registered.
- `alu_a` out 8: ALU operand A, registered.
- `alu_b` out 8: ALU operand B, registered.
- `alu_out` in 8: combinational ALU result.
- `alu_zero` in 1: ALU zero flag.
- `done` out 1: one-cycle pulse, instruction retired.
- `branch_taken` out 1: valid with `done`; beq condition true.
- `illegal` out 1: valid with `done`; instruction not decodable.
- `dbg_addr` in 5: register file debug read address.
- `dbg_data` out 8: combinational read of `regs[dbg_addr]`; `r0` always reads 0.

## Operation
- FSM states and transitions:
  - IDLE -> ISSUE on `instr_valid && instr_ready`.
  - ISSUE -> RETIRE unconditionally.
  - RETIRE -> IDLE unconditionally.
- `instr_ready` = 1 only in IDLE.
- On accept, the sequencer latches the decode results into `alu_ctl`/`alu_a`/`alu_b`, plus the destination, write-enable, branch and illegal flags.
- R-type decode (`op=0x00`), A=`regs[rs]`, B=`regs[rt]`, dest=`rd`:
  - funct 0x24 -> 0000 (and)
  - funct 0x25 -> 0001 (or)
  - funct 0x20 -> 0010 (add)
  - funct 0x22 -> 0110 (sub)
  - funct 0x2A -> 0111 (slt)
  - funct 0x27 -> 1100 (nor)
- I-type decode, A=`regs[rs]`, B=`imm[7:0]`, dest=`rt`:
  - `op=0x08` addi -> 0010
  - `op=0x0C` andi -> 0000
  - `op=0x0D` ori -> 0001
  - `op=0x0A` slti -> 0111
- beq (`op=0x04`): `alu_ctl`=0110, A=`regs[rs]`, B=`regs[rt]`, no writeback.
- Any other op or funct is illegal: `alu_ctl`=1111, A=B=0, no writeback.
- At the ISSUE->RETIRE edge, `alu_out` is sampled. If write-enable is set and dest != 0, `regs[dest] <= alu_out`. For beq, `branch_taken` is registered as `alu_zero`.
- RETIRE: `done`=1. `branch_taken` is 1 only for beq with zero. `illegal` is 1 only for an illegal instruction.
- Writes to `r0` are discarded, and `r0` reads as 0 on every read path.
- Arithmetic is 8-bit modulo, performed by the ALU; the sequencer never extends or saturates. Immediates use the low 8 bits only.
- No hazards: each instruction writes back before the next is accepted.

## Timing
- Reset values:
  - state IDLE
  - `instr_ready`=1
  - `alu_ctl`=1111
  - `alu_a`=`alu_b`=0
  - `done`=`branch_taken`=`illegal`=0
  - all registers 0
- Accept at edge N.
- `alu_ctl`/`alu_a`/`alu_b` are valid and stable for the whole ISSUE cycle (N to N+1). They hold their values until the next accept.
- Writeback happens at edge N+1. `done` is high from N+1 to N+2. `instr_ready` rises at N+2.
- Throughput is 1 instruction per 3 cycles.
- `dbg_data` reflects the new value starting at N+1.
- `instr_valid` while not ready is ignored, and `instr` is not sampled.
- `done`, `branch_taken` and `illegal` are 0 in every cycle except RETIRE.
- Reset asserted in ISSUE or RETIRE aborts immediately: no writeback and no `done`. All registers and outputs return to their reset values asynchronously.
- `alu_out` must settle within the ISSUE cycle; the ALU is a single combinational stage.

## Test plan
- Reset, then addi `r1 = r0 + 0x05` -> `alu_ctl`=0010, A=0x00, B=0x05 in ISSUE; `done` pulses; `dbg_data[1]`=0x05; `instr_ready` high 2 cycles after accept.
- With `r1`=0xF0 and `r2`=0x20, add `r3`=`r1`+`r2` -> `r3`=0x10 (wrap). Sub `r4`=`r2`-`r1` -> `r4`=0x30. Nor `r5` -> `r5`=0x0F. Slt `r6`=(`r2`<`r1`) -> 0x01.
- beq `r1`,`r1` -> `branch_taken`=1 with `done`, no register changes. beq `r1`,`r2` -> `branch_taken`=0.
- Op 0x3F, and R-type funct 0x00 -> `illegal`=1 with `done`, `alu_ctl`=1111, register file unchanged. Addi to `r0` with imm 0x7F -> `r0` still reads 0.
- Hold `instr_valid`=1 with changing `instr` during ISSUE/RETIRE -> only the instruction present at IDLE is accepted. Assert `reset` during ISSUE of add `r7` -> `r7`=0, no `done`, outputs at reset values.

Source files
------------

// File: rtl/mips_alu_issue.sv
// mips_alu_issue
//
// Issue and writeback sequencer for the 8-bit MIPS ALU subset. It accepts one
// instruction over a valid/ready handshake, decodes it into an ALU control code,
// and presents the operands from a 32 x 8-bit register file. One cycle later it
// captures the combinational ALU result and writes it back. Each instruction
// takes three cycles: IDLE (accept), ISSUE (operands on the ALU), RETIRE (done).
//
// Ports
//   clk          : single clock, all state changes on the rising edge
//   reset        : asynchronous, active-high, clears all state
//   instr_valid  : instruction offered
//   instr[31:0]  : MIPS instruction (op/rs/rt/rd/funct/imm fields)
//   instr_ready  : high only in IDLE, sequencer can accept
//   alu_ctl[3:0] : registered ALU operation code
//   alu_a[7:0]   : registered ALU operand A
//   alu_b[7:0]   : registered ALU operand B
//   alu_out[7:0] : combinational ALU result, sampled at the end of ISSUE
//   alu_zero     : ALU zero flag, sampled at the end of ISSUE
//   done         : one-cycle retire pulse
//   branch_taken : with done, beq condition true
//   illegal      : with done, instruction not decodable
//   dbg_addr[4:0]: register file debug read address
//   dbg_data[7:0]: combinational read of the addressed register (r0 reads 0)

module mips_alu_issue (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_valid,
    input  logic [31:0] instr,
    output logic        instr_ready,
    output logic [3:0]  alu_ctl,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    input  logic [7:0]  alu_out,
    input  logic        alu_zero,
    output logic        done,
    output logic        branch_taken,
    output logic        illegal,
    input  logic [4:0]  dbg_addr,
    output logic [7:0]  dbg_data
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_RETIRE = 2'd2
    } state_t;

    localparam logic [3:0] CTL_AND     = 4'b0000;
    localparam logic [3:0] CTL_OR      = 4'b0001;
    localparam logic [3:0] CTL_ADD     = 4'b0010;
    localparam logic [3:0] CTL_SUB     = 4'b0110;
    localparam logic [3:0] CTL_SLT     = 4'b0111;
    localparam logic [3:0] CTL_NOR     = 4'b1100;
    localparam logic [3:0] CTL_ILLEGAL = 4'b1111;

    state_t     state;
    logic [7:0] regs [32];

    // Writeback bookkeeping latched at accept and consumed at the end of ISSUE.
    logic [4:0] dest_p1;
    logic       wr_en_p1;
    logic       beq_p1;
    logic       ill_p1;

    // Instruction fields
    logic [5:0] op;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [5:0] funct;
    logic [7:0] imm;

    assign op    = instr[31:26];
    assign rs    = instr[25:21];
    assign rt    = instr[20:16];
    assign rd    = instr[15:11];
    assign funct = instr[5:0];
    assign imm   = instr[7:0];

    // Bits [10:8] belong to neither rd nor the 8-bit immediate.
    logic unused_instr_bits;
    assign unused_instr_bits = &{1'b0, instr[10:8]};

    // Register read ports; r0 is forced to zero on every read path.
    logic [7:0] rs_val;
    logic [7:0] rt_val;

    assign rs_val   = (rs == 5'd0) ? 8'h00 : regs[rs];
    assign rt_val   = (rt == 5'd0) ? 8'h00 : regs[rt];
    assign dbg_data = (dbg_addr == 5'd0) ? 8'h00 : regs[dbg_addr];

    // R-type funct to ALU code; CTL_ILLEGAL marks an undecodable funct.
    function automatic logic [3:0] rtype_ctl(input logic [5:0] f);
        case (f)
            6'h24:   rtype_ctl = CTL_AND;
            6'h25:   rtype_ctl = CTL_OR;
            6'h20:   rtype_ctl = CTL_ADD;
            6'h22:   rtype_ctl = CTL_SUB;
            6'h2A:   rtype_ctl = CTL_SLT;
            6'h27:   rtype_ctl = CTL_NOR;
            default: rtype_ctl = CTL_ILLEGAL;
        endcase
    endfunction

    // Combinational decode of the offered instruction.
    logic [3:0] dec_ctl;
    logic [7:0] dec_a;
    logic [7:0] dec_b;
    logic [4:0] dec_dest;
    logic       dec_we;
    logic       dec_beq;
    logic       dec_ill;

    always_comb begin
        dec_ctl  = CTL_ILLEGAL;
        dec_a    = 8'h00;
        dec_b    = 8'h00;
        dec_dest = 5'd0;
        dec_we   = 1'b0;
        dec_beq  = 1'b0;
        dec_ill  = 1'b1;
        case (op)
            6'h00: begin
                if (rtype_ctl(funct) != CTL_ILLEGAL) begin
                    dec_ctl  = rtype_ctl(funct);
                    dec_a    = rs_val;
                    dec_b    = rt_val;
                    dec_dest = rd;
                    dec_we   = 1'b1;
                    dec_ill  = 1'b0;
                end
            end
            6'h08, 6'h0C, 6'h0D, 6'h0A: begin
                case (op)
                    6'h08:   dec_ctl = CTL_ADD;
                    6'h0C:   dec_ctl = CTL_AND;
                    6'h0D:   dec_ctl = CTL_OR;
                    default: dec_ctl = CTL_SLT;
                endcase
                dec_a    = rs_val;
                dec_b    = imm;
                dec_dest = rt;
                dec_we   = 1'b1;
                dec_ill  = 1'b0;
            end
            6'h04: begin
                dec_ctl = CTL_SUB;
                dec_a   = rs_val;
                dec_b   = rt_val;
                dec_beq = 1'b1;
                dec_ill = 1'b0;
            end
            default: ;
        endcase
    end

    // Sequencer: every output is registered, and done/branch_taken/illegal
    // default low so they can only be high during RETIRE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            instr_ready  <= 1'b1;
            alu_ctl      <= CTL_ILLEGAL;
            alu_a        <= 8'h00;
            alu_b        <= 8'h00;
            done         <= 1'b0;
            branch_taken <= 1'b0;
            illegal      <= 1'b0;
            dest_p1      <= 5'd0;
            wr_en_p1     <= 1'b0;
            beq_p1       <= 1'b0;
            ill_p1       <= 1'b0;
            for (int i = 0; i < 32; i++) begin
                regs[i] <= 8'h00;
            end
        end else begin
            done         <= 1'b0;
            branch_taken <= 1'b0;
            illegal      <= 1'b0;
            case (state)
                // IDLE -> ISSUE: latch decode, operands stay stable until next accept
                S_IDLE: begin
                    if (instr_valid) begin
                        state       <= S_ISSUE;
                        instr_ready <= 1'b0;
                        alu_ctl     <= dec_ctl;
                        alu_a       <= dec_a;
                        alu_b       <= dec_b;
                        dest_p1     <= dec_dest;
                        wr_en_p1    <= dec_we;
                        beq_p1      <= dec_beq;
                        ill_p1      <= dec_ill;
                    end
                end
                // ISSUE -> RETIRE: sample the ALU, write back, raise retire flags
                S_ISSUE: begin
                    state        <= S_RETIRE;
                    done         <= 1'b1;
                    branch_taken <= beq_p1 & alu_zero;
                    illegal      <= ill_p1;
                    if (wr_en_p1 && (dest_p1 != 5'd0)) begin
                        regs[dest_p1] <= alu_out;
                    end
                end
                // RETIRE -> IDLE
                S_RETIRE: begin
                    state       <= S_IDLE;
                    instr_ready <= 1'b1;
                end
                default: begin
                    state       <= S_IDLE;
                    instr_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips_alu_issue.sv
module tb_mips_alu_issue;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_valid;
    logic [31:0] instr;
    logic        instr_ready;
    logic [3:0]  alu_ctl;
    logic [7:0]  alu_a, alu_b, alu_out;
    logic        alu_zero, done, branch_taken, illegal;
    logic [4:0]  dbg_addr;
    logic [7:0]  dbg_data;

    int checks = 0;
    int errors = 0;

    mips_alu_issue dut (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr(instr),
        .instr_ready(instr_ready), .alu_ctl(alu_ctl), .alu_a(alu_a), .alu_b(alu_b),
        .alu_out(alu_out), .alu_zero(alu_zero), .done(done),
        .branch_taken(branch_taken), .illegal(illegal),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    // Behavioural mipsALU driven by the sequencer (unsigned slt).
    always_comb begin
        case (alu_ctl)
            4'b0000: alu_out = alu_a & alu_b;
            4'b0001: alu_out = alu_a | alu_b;
            4'b0010: alu_out = alu_a + alu_b;
            4'b0110: alu_out = alu_a - alu_b;
            4'b0111: alu_out = (alu_a < alu_b) ? 8'h01 : 8'h00;
            4'b1100: alu_out = ~(alu_a | alu_b);
            default: alu_out = 8'h00;
        endcase
        alu_zero = (alu_out == 8'h00);
    end

    // Reference model state and expectations for the current instruction
    logic [7:0] mregs [32];
    logic [3:0] e_ctl;
    logic [7:0] e_a, e_b, e_res;
    logic       e_taken, e_ill, e_we;
    logic [4:0] e_dst;

    // Observations from exec
    logic [3:0] ob_ctl, ob_ctl_ret;
    logic [7:0] ob_a, ob_b, ob_dbg_ret;
    logic       ob_rdy_iss, ob_done_iss, ob_done, ob_bt, ob_ill, ob_rdy_ret;
    logic       ob_done_after, ob_rdy_after, ob_bt_after, ob_ill_after;

    function automatic logic [31:0] rtype(input logic [5:0] f, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [4:0] rd);
        return {6'h00, rs, rt, rd, 5'h00, f};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [7:0] imm);
        return {op, rs, rt, 8'h00, imm};
    endfunction

    // Instruction semantics by mnemonic; updates the model register file.
    task automatic model_step(input logic [31:0] ins);
        logic [7:0] ra, rb, im;
        ra = mregs[ins[25:21]];
        rb = mregs[ins[20:16]];
        im = ins[7:0];
        e_ctl = 4'hF; e_a = 8'h00; e_b = 8'h00; e_res = 8'h00;
        e_taken = 1'b0; e_ill = 1'b1; e_we = 1'b0; e_dst = 5'd0;
        if (ins[31:26] == 6'h00) begin
            e_ill = 1'b0; e_a = ra; e_b = rb; e_we = 1'b1; e_dst = ins[15:11];
            case (ins[5:0])
                6'h24: begin e_ctl = 4'b0000; e_res = ra & rb; end
                6'h25: begin e_ctl = 4'b0001; e_res = ra | rb; end
                6'h20: begin e_ctl = 4'b0010; e_res = ra + rb; end
                6'h22: begin e_ctl = 4'b0110; e_res = ra - rb; end
                6'h2A: begin e_ctl = 4'b0111; e_res = (ra < rb) ? 8'h01 : 8'h00; end
                6'h27: begin e_ctl = 4'b1100; e_res = ~(ra | rb); end
                default: begin e_ill = 1'b1; e_a = 8'h00; e_b = 8'h00; e_we = 1'b0; e_dst = 5'd0; end
            endcase
        end else begin
            case (ins[31:26])
                6'h08: begin e_ctl = 4'b0010; e_res = ra + im; end
                6'h0C: begin e_ctl = 4'b0000; e_res = ra & im; end
                6'h0D: begin e_ctl = 4'b0001; e_res = ra | im; end
                6'h0A: begin e_ctl = 4'b0111; e_res = (ra < im) ? 8'h01 : 8'h00; end
                6'h04: begin e_ctl = 4'b0110; e_a = ra; e_b = rb; e_taken = (ra == rb); e_ill = 1'b0; end
                default: ;
            endcase
            if (ins[31:26] inside {6'h08, 6'h0C, 6'h0D, 6'h0A}) begin
                e_ill = 1'b0; e_a = ra; e_b = im; e_we = 1'b1; e_dst = ins[20:16];
            end
        end
        if (e_we && e_dst != 5'd0) mregs[e_dst] = e_res;
    endtask

    // Drives one instruction from IDLE (called at posedge+1) and records outputs
    // in ISSUE, RETIRE and the following IDLE cycle. With hold set, instr_valid
    // stays high and instr changes every cycle while the sequencer is busy.
    task automatic exec(input logic [31:0] ins, input logic [4:0] dbg_a, input bit hold);
        instr = ins; instr_valid = 1'b1; dbg_addr = dbg_a;
        @(posedge clk); #1;
        ob_ctl = alu_ctl; ob_a = alu_a; ob_b = alu_b;
        ob_rdy_iss = instr_ready; ob_done_iss = done;
        if (hold) instr = $urandom; else instr_valid = 1'b0;
        @(posedge clk); #1;
        ob_done = done; ob_bt = branch_taken; ob_ill = illegal;
        ob_rdy_ret = instr_ready; ob_ctl_ret = alu_ctl; ob_dbg_ret = dbg_data;
        if (hold) instr = $urandom;
        @(posedge clk); #1;
        ob_done_after = done; ob_rdy_after = instr_ready;
        ob_bt_after = branch_taken; ob_ill_after = illegal;
        instr_valid = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1; instr_valid = 1'b0; instr = 32'h0; dbg_addr = 5'd0;
        for (int i = 0; i < 32; i++) mregs[i] = 8'h00;
        repeat (2) @(posedge clk); #1;
        checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", instr_ready); end
        checks++; if (alu_ctl !== 4'hF) begin errors++; $display("FAIL reset_ctl: got %h expected f", alu_ctl); end
        checks++; if (alu_a !== 8'h00 || alu_b !== 8'h00) begin errors++; $display("FAIL reset_ops: got %h/%h expected 00/00", alu_a, alu_b); end
        checks++; if ({done, branch_taken, illegal} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {done, branch_taken, illegal}); end
        for (int i = 0; i < 32; i++) begin
            dbg_addr = i[4:0]; #1;
            checks++; if (dbg_data !== 8'h00) begin errors++; $display("FAIL reset_reg[%0d]: got %h expected 00", i, dbg_data); end
        end
        reset = 1'b0;
        @(posedge clk); #1;
        checks++; if (instr_ready !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL idle_after_reset: got ready=%b done=%b expected 1/0", instr_ready, done); end
    endtask

    task automatic test_addi;
        logic [31:0] ins;
        ins = itype(6'h08, 5'd0, 5'd1, 8'h05);
        model_step(ins);
        exec(ins, 5'd1, 1'b0);
        checks++; if (ob_ctl !== 4'b0010) begin errors++; $display("FAIL addi_ctl: got %h expected 2", ob_ctl); end
        checks++; if (ob_a !== 8'h00 || ob_b !== 8'h05) begin errors++; $display("FAIL addi_ops: got %h/%h expected 00/05", ob_a, ob_b); end
        checks++; if (ob_rdy_iss !== 1'b0 || ob_done_iss !== 1'b0) begin errors++; $display("FAIL addi_issue: got ready=%b done=%b expected 0/0", ob_rdy_iss, ob_done_iss); end
        checks++; if (ob_done !== 1'b1 || ob_rdy_ret !== 1'b0) begin errors++; $display("FAIL addi_retire: got done=%b ready=%b expected 1/0", ob_done, ob_rdy_ret); end
        checks++; if (ob_dbg_ret !== 8'h05) begin errors++; $display("FAIL addi_wb: got %h expected 05", ob_dbg_ret); end
        checks++; if (ob_rdy_after !== 1'b1 || ob_done_after !== 1'b0) begin errors++; $display("FAIL addi_after: got ready=%b done=%b expected 1/0", ob_rdy_after, ob_done_after); end
        checks++; if (ob_ctl_ret !== 4'b0010) begin errors++; $display("FAIL addi_ctl_hold: got %h expected 2", ob_ctl_ret); end
    endtask

    task automatic test_arith;
        logic [31:0] prog [6];
        logic [7:0]  want [6];
        prog[0] = itype(6'h08, 5'd0, 5'd1, 8'hF0);   want[0] = 8'hF0;
        prog[1] = itype(6'h08, 5'd0, 5'd2, 8'h20);   want[1] = 8'h20;
        prog[2] = rtype(6'h20, 5'd1, 5'd2, 5'd3);    want[2] = 8'h10;
        prog[3] = rtype(6'h22, 5'd2, 5'd1, 5'd4);    want[3] = 8'h30;
        prog[4] = rtype(6'h27, 5'd1, 5'd2, 5'd5);    want[4] = 8'h0F;
        prog[5] = rtype(6'h2A, 5'd2, 5'd1, 5'd6);    want[5] = 8'h01;
        for (int k = 0; k < 6; k++) begin
            model_step(prog[k]);
            exec(prog[k], e_dst, 1'b0);
            checks++; if (ob_dbg_ret !== want[k]) begin errors++; $display("FAIL arith_wb[%0d]: got %h expected %h", k, ob_dbg_ret, want[k]); end
            checks++; if (ob_ctl !== e_ctl || ob_a !== e_a || ob_b !== e_b) begin errors++; $display("FAIL arith_issue[%0d]: got %h %h %h expected %h %h %h", k, ob_ctl, ob_a, ob_b, e_ctl, e_a, e_b); end
        end
    endtask

    task automatic test_beq;
        logic [31:0] ins;
        ins = itype(6'h04, 5'd1, 5'd1, 8'h00);
        model_step(ins);
        exec(ins, 5'd1, 1'b0);
        checks++; if (ob_done !== 1'b1 || ob_bt !== 1'b1 || ob_ill !== 1'b0) begin errors++; $display("FAIL beq_taken: got done=%b bt=%b ill=%b expected 1/1/0", ob_done, ob_bt, ob_ill); end
        checks++; if (ob_ctl !== 4'b0110 || ob_a !== 8'hF0 || ob_b !== 8'hF0) begin errors++; $display("FAIL beq_issue: got %h %h %h expected 6 f0 f0", ob_ctl, ob_a, ob_b); end
        checks++; if (ob_bt_after !== 1'b0) begin errors++; $display("FAIL beq_bt_after: got %b expected 0", ob_bt_after); end
        ins = itype(6'h04, 5'd1, 5'd2, 8'h00);
        model_step(ins);
        exec(ins, 5'd1, 1'b0);
        checks++; if (ob_done !== 1'b1 || ob_bt !== 1'b0) begin errors++; $display("FAIL beq_not_taken: got done=%b bt=%b expected 1/0", ob_done, ob_bt); end
        for (int i = 0; i < 32; i++) begin
            dbg_addr = i[4:0]; #1;
            checks++; if (dbg_data !== mregs[i]) begin errors++; $display("FAIL beq_regs[%0d]: got %h expected %h", i, dbg_data, mregs[i]); end
        end
    endtask

    task automatic test_illegal;
        logic [31:0] prog [2];
        logic [31:0] ins;
        prog[0] = {6'h3F, 5'd1, 5'd2, 5'd3, 11'h024};
        prog[1] = rtype(6'h00, 5'd1, 5'd2, 5'd3);
        for (int k = 0; k < 2; k++) begin
            model_step(prog[k]);
            exec(prog[k], 5'd3, 1'b0);
            checks++; if (ob_done !== 1'b1 || ob_ill !== 1'b1 || ob_bt !== 1'b0) begin errors++; $display("FAIL illegal_flags[%0d]: got done=%b ill=%b bt=%b expected 1/1/0", k, ob_done, ob_ill, ob_bt); end
            checks++; if (ob_ctl !== 4'hF || ob_a !== 8'h00 || ob_b !== 8'h00) begin errors++; $display("FAIL illegal_issue[%0d]: got %h %h %h expected f 00 00", k, ob_ctl, ob_a, ob_b); end
            checks++; if (ob_ill_after !== 1'b0) begin errors++; $display("FAIL illegal_after[%0d]: got %b expected 0", k, ob_ill_after); end
        end
        for (int i = 0; i < 32; i++) begin
            dbg_addr = i[4:0]; #1;
            checks++; if (dbg_data !== mregs[i]) begin errors++; $display("FAIL illegal_regs[%0d]: got %h expected %h", i, dbg_data, mregs[i]); end
        end
        ins = itype(6'h08, 5'd0, 5'd0, 8'h7F);
        model_step(ins);
        exec(ins, 5'd0, 1'b0);
        checks++; if (ob_dbg_ret !== 8'h00 || ob_ill !== 1'b0) begin errors++; $display("FAIL r0_write: got r0=%h ill=%b expected 00/0", ob_dbg_ret, ob_ill); end
        ins = rtype(6'h20, 5'd0, 5'd1, 5'd9);
        model_step(ins);
        exec(ins, 5'd9, 1'b0);
        checks++; if (ob_a !== 8'h00 || ob_dbg_ret !== mregs[9]) begin errors++; $display("FAIL r0_read: got a=%h r9=%h expected 00/%h", ob_a, ob_dbg_ret, mregs[9]); end
    endtask

    task automatic test_hold_valid;
        logic [31:0] ins;
        ins = rtype(6'h20, 5'd1, 5'd2, 5'd7);
        model_step(ins);
        exec(ins, 5'd7, 1'b1);
        checks++; if (ob_dbg_ret !== mregs[7] || ob_done !== 1'b1) begin errors++; $display("FAIL hold_wb: got r7=%h done=%b expected %h/1", ob_dbg_ret, ob_done, mregs[7]); end
        checks++; if (ob_ctl_ret !== 4'b0010 || ob_rdy_ret !== 1'b0) begin errors++; $display("FAIL hold_busy: got ctl=%h ready=%b expected 2/0", ob_ctl_ret, ob_rdy_ret); end
        checks++; if (ob_done_after !== 1'b0 || ob_rdy_after !== 1'b1) begin errors++; $display("FAIL hold_after: got done=%b ready=%b expected 0/1", ob_done_after, ob_rdy_after); end
        for (int i = 0; i < 32; i++) begin
            dbg_addr = i[4:0]; #1;
            checks++; if (dbg_data !== mregs[i]) begin errors++; $display("FAIL hold_regs[%0d]: got %h expected %h", i, dbg_data, mregs[i]); end
        end
    endtask

    task automatic test_random;
        logic [31:0] ins;
        logic [5:0]  ops [6];
        logic [5:0]  fns [7];
        logic [4:0]  probe;
        ops = '{6'h08, 6'h0C, 6'h0D, 6'h0A, 6'h04, 6'h00};
        fns = '{6'h24, 6'h25, 6'h20, 6'h22, 6'h2A, 6'h27, 6'h21};
        for (int k = 0; k < 60; k++) begin
            ins = $urandom;
            ins[25:21] = 5'($urandom_range(0, 7));
            ins[20:16] = 5'($urandom_range(0, 7));
            ins[15:11] = 5'($urandom_range(0, 7));
            if ($urandom_range(0, 9) != 0) ins[31:26] = ops[$urandom_range(0, 5)];
            if (ins[31:26] == 6'h00) ins[5:0] = fns[$urandom_range(0, 6)];
            model_step(ins);
            exec(ins, e_dst, ($urandom_range(0, 3) == 0));
            checks++; if (ob_ctl !== e_ctl || ob_a !== e_a || ob_b !== e_b) begin errors++; $display("FAIL rand_issue[%0d]: ins=%h got %h %h %h expected %h %h %h", k, ins, ob_ctl, ob_a, ob_b, e_ctl, e_a, e_b); end
            checks++; if (ob_done !== 1'b1 || ob_bt !== e_taken || ob_ill !== e_ill) begin errors++; $display("FAIL rand_retire[%0d]: ins=%h got done=%b bt=%b ill=%b expected 1/%b/%b", k, ins, ob_done, ob_bt, ob_ill, e_taken, e_ill); end
            checks++; if (ob_dbg_ret !== mregs[e_dst]) begin errors++; $display("FAIL rand_wb[%0d]: ins=%h got %h expected %h", k, ins, ob_dbg_ret, mregs[e_dst]); end
            checks++; if (ob_done_iss !== 1'b0 || ob_done_after !== 1'b0 || ob_rdy_after !== 1'b1) begin errors++; $display("FAIL rand_timing[%0d]: got done_iss=%b done_after=%b ready_after=%b expected 0/0/1", k, ob_done_iss, ob_done_after, ob_rdy_after); end
            probe = 5'($urandom_range(0, 31));
            dbg_addr = probe; #1;
            checks++; if (dbg_data !== mregs[probe]) begin errors++; $display("FAIL rand_probe[%0d]: r%0d got %h expected %h", k, probe, dbg_data, mregs[probe]); end
        end
    endtask

    task automatic test_reset_mid_issue;
        logic [31:0] ins;
        ins = rtype(6'h20, 5'd1, 5'd2, 5'd7);
        instr = ins; instr_valid = 1'b1; dbg_addr = 5'd7;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        reset = 1'b1; #1;
        checks++; if (instr_ready !== 1'b1 || alu_ctl !== 4'hF || alu_a !== 8'h00 || alu_b !== 8'h00) begin errors++; $display("FAIL abort_outputs: got ready=%b ctl=%h a=%h b=%h expected 1 f 00 00", instr_ready, alu_ctl, alu_a, alu_b); end
        for (int i = 0; i < 32; i++) mregs[i] = 8'h00;
        @(posedge clk); #1;
        checks++; if (done !== 1'b0 || dbg_data !== 8'h00) begin errors++; $display("FAIL abort_no_done: got done=%b r7=%h expected 0/00", done, dbg_data); end
        dbg_addr = 5'd1; #1;
        checks++; if (dbg_data !== 8'h00) begin errors++; $display("FAIL abort_regs: got r1=%h expected 00", dbg_data); end
        reset = 1'b0;
        @(posedge clk); #1;
        checks++; if (done !== 1'b0 || instr_ready !== 1'b1) begin errors++; $display("FAIL abort_idle: got done=%b ready=%b expected 0/1", done, instr_ready); end
        ins = itype(6'h0D, 5'd0, 5'd7, 8'h5A);
        model_step(ins);
        exec(ins, 5'd7, 1'b0);
        checks++; if (ob_dbg_ret !== 8'h5A || ob_done !== 1'b1) begin errors++; $display("FAIL abort_resume: got r7=%h done=%b expected 5a/1", ob_dbg_ret, ob_done); end
    endtask

    initial begin
        test_reset;
        test_addi;
        test_arith;
        test_beq;
        test_illegal;
        test_hold_valid;
        test_random;
        test_reset_mid_issue;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
